program_loader: RTL

// Byte-stream writer for the CPU's 256x16 instruction memory (single-port, 8-bit address, 16-bit word).

---
 rtl/program_loader.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// program_loader: receives a framed program image from a byte stream and writes it word by word
// into a 256x16 instruction memory. The CPU is held in reset until the image is complete and valid.
// Frame: SYNC_BYTE, COUNT (0 = 256 words), N x {hi, lo}, optional CHECKSUM.
// Define PROGRAM_LOADER_CHECKSUM_EN to require the trailing checksum byte.
module program_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  BASE_ADDRESS   = 8'h00,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        program_write,
  output logic [7:0]  program_address,
  output logic [15:0] program_data,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [8:0]  words_loaded
);

  localparam logic [15:0] TimeoutLimit = TIMEOUT_CYCLES[15:0];
  localparam bit          TimeoutEn    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [3:0] {
    StIdle,
    StSync,
    StCount,
    StHi,
    StLo,
    StWrite,
    StDone,
    StError
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    , StCheck
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [8:0]  count_q, count_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  addr_q, addr_d;
  logic [8:0]  words_q, words_d;
  logic [15:0] timer_q, timer_d;
  logic        rx_ready_q, rx_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        cpu_reset_q, cpu_reset_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
`endif

  logic xfer;
  logic timing;

  assign xfer = rx_valid & rx_ready_q;

  // Next-state, datapath and registered-flag computation.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    addr_d  = addr_q;
    words_d = words_q;
    timer_d = timer_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    timing  = 1'b0;

    case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d = StSync;
          addr_d  = BASE_ADDRESS;
          words_d = '0;
          timer_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      StSync: begin
        if (xfer && (rx_data == SYNC_BYTE)) begin
          state_d = StCount;
          timer_d = '0;
        end
      end
      StCount: begin
        timing = 1'b1;
        if (xfer) begin
          // A count byte of zero encodes a full 256-word image.
          count_d = {(rx_data == 8'h00), rx_data};
          state_d = StHi;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d   = rx_data;
`endif
        end
      end
      StHi: begin
        timing = 1'b1;
        if (xfer) begin
          hi_d    = rx_data;
          state_d = StLo;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d   = sum_q + rx_data;
`endif
        end
      end
      StLo: begin
        timing = 1'b1;
        if (xfer) begin
          lo_d    = rx_data;
          state_d = StWrite;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d   = sum_q + rx_data;
`endif
        end
      end
      StWrite: begin
        addr_d  = addr_q + 8'd1;
        words_d = words_q + 9'd1;
        if (words_d == count_q) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StDone;
`endif
        end else begin
          state_d = StHi;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      StCheck: begin
        timing = 1'b1;
        if (xfer) begin
          state_d = (rx_data == sum_q) ? StDone : StError;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    // Inter-byte watchdog; an accepted byte always wins over an expiring timer.
    if (timing) begin
      if (xfer) begin
        timer_d = '0;
      end else begin
        timer_d = timer_q + 16'd1;
        if (TimeoutEn && (timer_d == TimeoutLimit)) begin
          state_d = StError;
        end
      end
    end

    rx_ready_d  = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    error_d     = 1'b0;
    cpu_reset_d = 1'b0;
    case (state_d)
      StSync, StCount, StHi, StLo: begin
        rx_ready_d  = 1'b1;
        busy_d      = 1'b1;
        cpu_reset_d = 1'b1;
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      StCheck: begin
        rx_ready_d  = 1'b1;
        busy_d      = 1'b1;
        cpu_reset_d = 1'b1;
      end
`endif
      StWrite: begin
        busy_d      = 1'b1;
        cpu_reset_d = 1'b1;
      end
      StError: begin
        error_d     = 1'b1;
        cpu_reset_d = 1'b1;
      end
      StDone:  done_d = 1'b1;
      default: ;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      count_q     <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      addr_q      <= '0;
      words_q     <= '0;
      timer_q     <= '0;
      rx_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_reset_q <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      addr_q      <= addr_d;
      words_q     <= words_d;
      timer_q     <= timer_d;
      rx_ready_q  <= rx_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      cpu_reset_q <= cpu_reset_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign program_write   = (state_q == StWrite);
  assign program_address = addr_q;
  assign program_data    = {hi_q, lo_q};
  assign rx_ready        = rx_ready_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;
  assign cpu_reset       = cpu_reset_q;
  assign words_loaded    = words_q;

endmodule
